// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if
//   Groups every bus-level signal around the arbiter: the IF (inst_*) and
//   EX (data_*) requester ports, the shared memory port towards the
//   sram-to-AXI bridge (mem_*), and the sticky stray-response flag.
//
//   Handshake semantics, shared by every request channel:
//     A requester raises *_req with a stable *_cmd and holds both until the
//     cycle in which *_addr_ok is high. That cycle is the handshake. The
//     command is consumed, and the requester may present a new one next cycle.
//     *_data_ok is a single-cycle pulse qualifying *_rdata. It has no
//     back-pressure. Responses come back in the same order as the handshakes.
//
//   Modports:
//     slave  - the arbiter's view (requests/mem responses in, grants/routed data out)
//     master - the environment's view (the reverse direction)
interface mem_req_arbiter_if;
  logic        inst_req;
  logic [70:0] inst_cmd;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [70:0] data_cmd;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic [70:0] mem_cmd;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        err_stray_ok;

  modport slave (
    input  inst_req, inst_cmd, data_req, data_cmd,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_cmd, err_stray_ok
  );

  modport master (
    output inst_req, inst_cmd, data_req, data_cmd,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_cmd, err_stray_ok
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one sram-like memory port between the IF instruction requester
//   and the EX data requester. Data normally has priority. Instruction
//   fetch is forced through after STARVE_LIMIT data grants in a row while
//   it waited. Once a request is presented to the bridge, the grant stays
//   locked until mem_addr_ok. The owner of every accepted transaction is
//   pushed into an in-order ID FIFO. Each response is steered to the
//   owner at the FIFO head.
//
// Ports
//   clk               clock, all state on posedge
//   resetn            synchronous active-low reset
//   io_bus            mem_req_arbiter_if.slave (inst_*, data_*, mem_*, err_stray_ok)
//   o_dbg_locked      1 while the lock FSM is in LOCKED
//   o_dbg_lock_id     owner held by the lock (0=inst, 1=data)
//   o_dbg_count       number of accepted-but-unanswered transactions
//   o_dbg_starve_cnt  consecutive data grants while inst was waiting
module mem_req_arbiter #(
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int STARVE_LIMIT    = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING) + 1,
  localparam int SW              = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  mem_req_arbiter_if.slave       io_bus,
  output logic                   o_dbg_locked,
  output logic                   o_dbg_lock_id,
  output logic [CW-1:0]          o_dbg_count,
  output logic [SW-1:0]          o_dbg_starve_cnt
);

  localparam int            PW       = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_lock_id;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve_cnt;
  logic          r_err;
  logic          r_id_fifo [MAX_OUTSTANDING];

  logic w_data_first;
  logic w_grant_id;
  logic w_grant_req;
  logic w_mem_req;
  logic w_push;
  logic w_pop;
  logic w_fifo_empty;
  logic w_head;

  // Grant selection. With no requester, the id defaults to data, so mem_cmd
  // mirrors data_cmd. w_grant_req is then 0, so nothing is issued.
  always_comb begin
    w_data_first = io_bus.data_req &&
                   ((r_starve_cnt < STARVE_C) || !io_bus.inst_req);
    w_grant_id   = 1'b1;
    if (r_state == ST_LOCKED) begin
      w_grant_id = r_lock_id;
    end else if (w_data_first) begin
      w_grant_id = 1'b1;
    end else if (io_bus.inst_req) begin
      w_grant_id = 1'b0;
    end
    w_grant_req = w_grant_id ? io_bus.data_req : io_bus.inst_req;
  end

  assign w_fifo_empty = (r_count == '0);
  assign w_mem_req    = resetn && w_grant_req && (r_count < MAX_C);
  assign w_push       = w_mem_req && io_bus.mem_addr_ok;
  // A full FIFO only stalls new requests. Responses always drain.
  assign w_pop        = resetn && io_bus.mem_data_ok && !w_fifo_empty;
  assign w_head       = r_id_fifo[r_rptr];

  assign io_bus.mem_req      = w_mem_req;
  assign io_bus.mem_cmd      = w_grant_id ? io_bus.data_cmd : io_bus.inst_cmd;
  assign io_bus.inst_addr_ok = w_push && !w_grant_id;
  assign io_bus.data_addr_ok = w_push && w_grant_id;
  assign io_bus.inst_data_ok = w_pop && !w_head;
  assign io_bus.data_data_ok = w_pop && w_head;
  assign io_bus.inst_rdata   = io_bus.mem_rdata;
  assign io_bus.data_rdata   = io_bus.mem_rdata;
  assign io_bus.err_stray_ok = r_err;

  assign o_dbg_locked     = (r_state == ST_LOCKED);
  assign o_dbg_lock_id    = r_lock_id;
  assign o_dbg_count      = r_count;
  assign o_dbg_starve_cnt = r_starve_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_UNLOCKED;
      r_lock_id    <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_err        <= 1'b0;
    end else begin
      // Lock FSM: once a request is presented unanswered, its owner is
      // frozen. This keeps mem_req/mem_cmd stable until the bridge accepts.
      case (r_state)
        ST_UNLOCKED: begin
          if (w_mem_req && !io_bus.mem_addr_ok) begin
            r_state   <= ST_LOCKED;
            r_lock_id <= w_grant_id;
          end
        end
        ST_LOCKED: begin
          if (io_bus.mem_addr_ok) begin
            r_state <= ST_UNLOCKED;
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase

      if ((w_push && !w_grant_id) || !io_bus.inst_req) begin
        r_starve_cnt <= '0;
      end else if (w_push && w_grant_id && (r_starve_cnt < STARVE_C)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      // Pointers wrap naturally because the depth is a power of two.
      if (w_push) begin
        r_id_fifo[r_wptr] <= w_grant_id;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (io_bus.mem_data_ok && w_fifo_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int MAXO   = 4;
  localparam int STARVE = 4;
  localparam int G_INST = 0;
  localparam int G_DATA = 1;
  localparam int G_NONE = 2;

  logic       clk;
  logic       resetn;
  logic       dbg_locked;
  logic       dbg_lock_id;
  logic [2:0] dbg_count;
  logic [2:0] dbg_starve;

  mem_req_arbiter_if bus();

  mem_req_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (STARVE)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .io_bus           (bus),
    .o_dbg_locked     (dbg_locked),
    .o_dbg_lock_id    (dbg_lock_id),
    .o_dbg_count      (dbg_count),
    .o_dbg_starve_cnt (dbg_starve)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [0:0]  exp_q[$];        // owners of outstanding transactions, oldest first
  logic        m_locked = 1'b0;
  int          m_owner  = 0;
  int          m_starve = 0;
  logic        m_err    = 1'b0;

  logic [0:0]  acc_log[$];      // owners seen handshaking, in order
  logic [31:0] inst_rx[$];
  logic [31:0] data_rx[$];

  int          g;
  logic        e_req, e_hs, e_pop, e_head;
  logic [70:0] e_cmd;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] mk_cmd(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wdata);
    return {wr, 2'd2, 4'hf, addr, wdata};
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    chk("err_stray_ok", {70'd0, bus.err_stray_ok}, {70'd0, m_err});
    chk("count", {68'd0, dbg_count}, 71'(exp_q.size()));
    chk("locked", {70'd0, dbg_locked}, {70'd0, m_locked});
    if (m_locked) chk("lock_id", {70'd0, dbg_lock_id}, 71'(m_owner));
    chk("starve_cnt", {68'd0, dbg_starve}, 71'(m_starve));

    if (bus.inst_addr_ok) acc_log.push_back(1'b0);
    if (bus.data_addr_ok) acc_log.push_back(1'b1);
    if (bus.inst_data_ok) inst_rx.push_back(bus.inst_rdata);
    if (bus.data_data_ok) data_rx.push_back(bus.data_rdata);

    if (!resetn) begin
      chk("rst_mem_req", {70'd0, bus.mem_req}, 71'd0);
      chk("rst_inst_addr_ok", {70'd0, bus.inst_addr_ok}, 71'd0);
      chk("rst_data_addr_ok", {70'd0, bus.data_addr_ok}, 71'd0);
      chk("rst_inst_data_ok", {70'd0, bus.inst_data_ok}, 71'd0);
      chk("rst_data_data_ok", {70'd0, bus.data_data_ok}, 71'd0);
      m_locked = 1'b0;
      m_starve = 0;
      m_err    = 1'b0;
      exp_q.delete();
    end else begin
      if (m_locked) g = m_owner;
      else if (bus.data_req && (m_starve < STARVE || !bus.inst_req)) g = G_DATA;
      else if (bus.inst_req) g = G_INST;
      else g = G_NONE;

      e_req  = ((g == G_INST) ? bus.inst_req : (g == G_DATA) ? bus.data_req : 1'b0)
               && (exp_q.size() < MAXO);
      e_cmd  = (g == G_INST) ? bus.inst_cmd : bus.data_cmd;
      e_hs   = e_req && bus.mem_addr_ok;
      e_pop  = bus.mem_data_ok && (exp_q.size() > 0);
      e_head = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;

      chk("mem_req", {70'd0, bus.mem_req}, {70'd0, e_req});
      chk("mem_cmd", bus.mem_cmd, e_cmd);
      chk("inst_addr_ok", {70'd0, bus.inst_addr_ok}, {70'd0, e_hs && g == G_INST});
      chk("data_addr_ok", {70'd0, bus.data_addr_ok}, {70'd0, e_hs && g == G_DATA});
      chk("inst_data_ok", {70'd0, bus.inst_data_ok}, {70'd0, e_pop && !e_head});
      chk("data_data_ok", {70'd0, bus.data_data_ok}, {70'd0, e_pop && e_head});
      if (e_pop) begin
        chk("rdata_route", {39'd0, (e_head ? bus.data_rdata : bus.inst_rdata)},
            {39'd0, bus.mem_rdata});
      end

      // advance the model
      if (bus.mem_data_ok && exp_q.size() == 0) m_err = 1'b1;
      if (e_pop) void'(exp_q.pop_front());
      if (e_hs) exp_q.push_back(1'(g));
      if (!m_locked && e_req && !bus.mem_addr_ok) begin
        m_locked = 1'b1;
        m_owner  = g;
      end else if (m_locked && bus.mem_addr_ok) begin
        m_locked = 1'b0;
      end
      if ((e_hs && g == G_INST) || !bus.inst_req) m_starve = 0;
      else if (e_hs && g == G_DATA && m_starve < STARVE) m_starve++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [0:0] seq1 [10];
  logic [31:0] exp_inst_rx [2];

  initial begin
    seq1        = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_inst_rx = '{32'h11, 32'h33};

    resetn       = 1'b0;
    bus.inst_cmd = mk_cmd(1'b0, 32'h1000_0000, 32'h0);
    bus.data_cmd = mk_cmd(1'b1, 32'h2000_0000, 32'hdead_beef);
    idle_inputs();
    cyc();
    cyc();
    @(negedge clk);
    chk("reset_count", {68'd0, dbg_count}, 71'd0);
    chk("reset_err", {70'd0, bus.err_stray_ok}, 71'd0);
    resetn = 1'b1;
    cyc();

    // 1: both requesting every cycle, bridge always ready
    acc_log.delete();
    bus.inst_req    = 1'b1;
    bus.data_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    cyc();
    for (int i = 1; i < 10; i++) begin
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = 32'h100 + 32'(i);
      cyc();
    end
    bus.inst_req  = 1'b0;
    bus.data_req  = 1'b0;
    bus.mem_rdata = 32'h10a;
    cyc();
    idle_inputs();
    cyc();
    chk("t1_grants", 71'(acc_log.size()), 71'd10);
    for (int i = 0; i < 10 && i < acc_log.size(); i++) begin
      chk($sformatf("t1_grant%0d", i), {70'd0, acc_log[i]}, {70'd0, seq1[i]});
    end

    // 2: inst held without addr_ok, data arrives while inst is locked
    bus.inst_cmd = mk_cmd(1'b0, 32'h0000_0a00, 32'h0);
    bus.data_cmd = mk_cmd(1'b0, 32'h0000_0b00, 32'h0);
    bus.inst_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_req = (i >= 1);
      @(negedge clk);
      chk("t2_mem_cmd_inst", bus.mem_cmd, mk_cmd(1'b0, 32'h0000_0a00, 32'h0));
      chk("t2_mem_req", {70'd0, bus.mem_req}, 71'd1);
      chk("t2_no_data_ok", {70'd0, bus.data_addr_ok}, 71'd0);
      cyc();
    end
    bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t2_inst_accept", {70'd0, bus.inst_addr_ok}, 71'd1);
    cyc();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk("t2_data_next", {70'd0, bus.data_addr_ok}, 71'd1);
    cyc();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'ha1;
    @(negedge clk);
    chk("t2_resp_inst", {70'd0, bus.inst_data_ok}, 71'd1);
    cyc();
    bus.mem_rdata = 32'hb2;
    @(negedge clk);
    chk("t2_resp_data", {70'd0, bus.data_data_ok}, 71'd1);
    cyc();
    idle_inputs();
    cyc();

    // 3: fill to MAX_OUTSTANDING, then pop and request in the same cycle
    bus.data_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_cmd = mk_cmd(1'b0, 32'h3000_0000 + 32'(4 * i), 32'h0);
      cyc();
    end
    @(negedge clk);
    chk("t3_full_no_req", {70'd0, bus.mem_req}, 71'd0);
    chk("t3_full_count", {68'd0, dbg_count}, 71'd4);
    cyc();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h3c;
    @(negedge clk);
    chk("t3_pop_when_full", {70'd0, bus.data_data_ok}, 71'd1);
    chk("t3_no_push_same", {70'd0, bus.data_addr_ok}, 71'd0);
    cyc();
    bus.mem_data_ok = 1'b0;
    @(negedge clk);
    chk("t3_push_next", {70'd0, bus.data_addr_ok}, 71'd1);
    chk("t3_count3", {68'd0, dbg_count}, 71'd3);
    cyc();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    idle_inputs();
    cyc();

    // 4: I,D,I then responses 0x11,0x22,0x33
    bus.mem_addr_ok = 1'b1;
    bus.inst_req = 1'b1; cyc();
    bus.inst_req = 1'b0; bus.data_req = 1'b1; cyc();
    bus.data_req = 1'b0; bus.inst_req = 1'b1; cyc();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    inst_rx.delete();
    data_rx.delete();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata = 32'h11; cyc();
    bus.mem_rdata = 32'h22; cyc();
    bus.mem_rdata = 32'h33; cyc();
    idle_inputs();
    cyc();
    chk("t4_inst_rx_n", 71'(inst_rx.size()), 71'd2);
    chk("t4_data_rx_n", 71'(data_rx.size()), 71'd1);
    for (int i = 0; i < 2 && i < inst_rx.size(); i++) begin
      chk($sformatf("t4_inst_rx%0d", i), {39'd0, inst_rx[i]}, {39'd0, exp_inst_rx[i]});
    end
    if (data_rx.size() > 0) chk("t4_data_rx0", {39'd0, data_rx[0]}, 71'h22);

    // 5: stray response
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h55;
    @(negedge clk);
    chk("t5_no_inst_ok", {70'd0, bus.inst_data_ok}, 71'd0);
    chk("t5_no_data_ok", {70'd0, bus.data_data_ok}, 71'd0);
    cyc();
    bus.mem_data_ok = 1'b0;
    @(negedge clk);
    chk("t5_err_set", {70'd0, bus.err_stray_ok}, 71'd1);
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    chk("t5_err_sticky", {70'd0, bus.err_stray_ok}, 71'd1);
    cyc();

    // 6: reset while LOCKED with two outstanding
    bus.inst_req    = 1'b1;
    bus.data_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    cyc();
    cyc();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    cyc();
    @(negedge clk);
    chk("t6_locked", {70'd0, dbg_locked}, 71'd1);
    chk("t6_lock_inst", {70'd0, dbg_lock_id}, 71'd0);
    chk("t6_count2", {68'd0, dbg_count}, 71'd2);
    chk("t6_starve2", {68'd0, dbg_starve}, 71'd2);
    cyc();
    resetn          = 1'b0;
    bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("t6_rst_mem_req", {70'd0, bus.mem_req}, 71'd0);
    chk("t6_rst_addr_ok", {70'd0, bus.inst_addr_ok}, 71'd0);
    cyc();
    resetn = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("t6_count0", {68'd0, dbg_count}, 71'd0);
    chk("t6_unlocked", {70'd0, dbg_locked}, 71'd0);
    chk("t6_starve0", {68'd0, dbg_starve}, 71'd0);
    chk("t6_err0", {70'd0, bus.err_stray_ok}, 71'd0);
    chk("t6_mem_req0", {70'd0, bus.mem_req}, 71'd0);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
